fb_scanout: RTL and testbench
=============================

# fb_scanout

Parametrised frame-buffer scanout engine for the VGA output path. It generates VGA timing and issues scaled read addresses into a block-RAM frame buffer. It unpacks 8 bpp (RGB332) or 16 bpp (RGB565) pixels into 4-bit VGA channels, and supports tear-free double buffering by swapping the frame base address only at the frame boundary. It sits between the frame-buffer RAM read port and the board VGA pins, and replaces the fixed-format, fixed-base scanout top.

## Interface
- H_VIS_AREA_PXL, 800, visible pixels per line
- H_FRONT_PORCH_PXL / H_SYNC_PULSE_PXL / H_BACK_PORCH_PXL, 40 / 128 / 88, horizontal timing
- V_VIS_AREA_PXL, 600, visible lines
- V_FRONT_PORCH_PXL / V_SYNC_PULSE_PXL / V_BACK_PORCH_PXL, 1 / 4 / 23, vertical timing
- SCALE_LOG2, 1, downscale shift (legal values 0..3); each source pixel is shown as a 2^SCALE_LOG2 square
- BPP, 8, bits per pixel; 8 = RGB332, 16 = RGB565
- FRAME_BUFFER_READ_LATENCY, 1, RAM read latency in cycles (legal values 1..4)
- SYNC_ACTIVE_HIGH, 1, sync pulse polarity
- vga_clk  in  1  pixel clock
- resetn  in  1  asynchronous active-low reset
- fb_base_in  in  32  byte address of the next frame buffer
- swap_req  in  1  request to adopt fb_base_in; held until swap_ack
- swap_ack  out  1  one-cycle pulse when the new base becomes active
- frame_start  out  1  one-cycle pulse when the counters are at (0,0)
- buffer_addr  out  32  byte address to the RAM
- buffer_en  out  1  RAM read enable
- buffer_dout  in  32  RAM word, FRAME_BUFFER_READ_LATENCY cycles after the address
- VGA_R / VGA_G / VGA_B  out  4 each  colour
- VGA_HS / VGA_VS  out  1 each  sync

## Operation
- **Totals.** H_TOTAL = sum of the four horizontal parameters (1056). V_TOTAL = sum of the four vertical parameters (628).
- **Counters.**
  - h counts 0..H_TOTAL-1 and wraps to 0.
  - v increments when h wraps, counts 0..V_TOTAL-1, and wraps to 0.
- **Visible area:** h < H_VIS_AREA_PXL and v < V_VIS_AREA_PXL.
- **Sync windows:**
  - HS is active for H_VIS+H_FP ≤ h < H_VIS+H_FP+H_SYNC.
  - VS is active for V_VIS+V_FP ≤ v < V_VIS+V_FP+V_SYNC.
- **Source pixel index:** idx = (v>>SCALE_LOG2)·(H_VIS_AREA_PXL>>SCALE_LOG2) + (h>>SCALE_LOG2). Width is 32 bits and the arithmetic is unsigned.
- **RAM address:**
  - buffer_addr = active_base + idx·(BPP/8).
  - buffer_en = 1 only while visible; otherwise buffer_en = 0 and buffer_addr = active_base.
- **Lane select.** Use buffer_addr[1:0] delayed by the read latency.
  - 8 bpp: byte lane addr[1:0].
  - 16 bpp: halfword lane addr[1]; addr[0] is always 0.
- **Colour expansion:**
  - RGB332 gives R = {r[2:0], r[2]}, G = {g[2:0], g[2]}, B = {b[1:0], b[1:0]}.
  - RGB565 gives R = r[4:1], G = g[5:2], B = b[4:1].
- **Blanking.** Outside the visible area, colour outputs are 0.
- **Double buffering:**
  - A cycle with swap_req = 1 captures fb_base_in into pending_base and sets pending_valid. A later capture in the same frame overwrites it; the last one wins.
  - On the wrap cycle (h = H_TOTAL-1, v = V_TOTAL-1), if pending_valid (or swap_req is high that same cycle, which takes priority): active_base ← pending value, pending_valid ← 0, and swap_ack pulses in that cycle.
  - The requester must drop swap_req in the cycle after swap_ack. A level still high then is treated as a new request.
- **Reset (async assert, sync release):**
  - h = v = 0.
  - active_base = 0 and pending_valid = 0.
  - All delay stages are cleared.
  - Colour = 0, HS/VS inactive (0 when SYNC_ACTIVE_HIGH = 1), buffer_en = 0, buffer_addr = 0, swap_ack = frame_start = 0.
  - Reset mid-frame restarts the frame at (0,0) and discards any pending swap.

## Timing
- Address, buffer_en, frame_start and swap_ack are combinational from the counter and base registers, in the counter cycle.
- Colour, HS and VS are registered outputs. They correspond to the counter value from L = FRAME_BUFFER_READ_LATENCY+1 cycles earlier.
- Visible-flag, lane and sync are delayed through an L-stage pipeline, so colour and sync stay aligned.
- The first visible pixel of a frame appears on the pins L cycles after frame_start.
- A swap issued in frame N takes effect on the first address of frame N+1; no mixed-base frame is possible.

## Structure
- **Package fb_pkg:**
  - Colour-expansion functions for RGB332 and RGB565.
  - Timing-total constants.
  - Mode encodings BPP_8 and BPP_16.
- **Sub-module scan_timing:**
  - Holds the h/v counters and the visible/HS/VS decode.
  - Outputs h, v, visible, hs_raw, vs_raw and wrap.
  - The top keeps base registers, address arithmetic, delay pipeline and unpacking.

## Test plan
- **Reset and basic timing.** Hold resetn = 0 for 5 cycles, then release. Required:
  - All outputs hold their reset values during reset.
  - frame_start pulses on the first cycle after release and then every 1056·628 cycles.
  - Each line has exactly 128 HS-active cycles starting at h = 840.
  - Each frame has 4 VS-active lines starting at v = 601.
- **8 bpp scaling.** SCALE_LOG2 = 1, base 0, word at address 0 = 0x1C_E0_03_FF. Required:
  - Pins h = 0,1 show byte 0xFF → R = F, G = F, B = F.
  - Pins h = 2,3 show 0x03 → R = 0, G = 0, B = F.
  - At h = 0, v = 2 the address is 400.
- **16 bpp mode.** BPP = 16, SCALE_LOG2 = 0, word 0x001F_F800. Required:
  - Pixel 0 (0xF800) → R = F, G = 0, B = 0.
  - Pixel 1 (0x001F) → R = 0, G = 0, B = F.
  - Pixel 1 address is 2.
- **Double-buffer swap.** Assert swap_req with 0x0001_0000 mid-frame. Required:
  - swap_ack pulses at (1055, 627).
  - The first visible address of the next frame is 0x0001_0000; the current frame keeps the old base.
  - Two requests in one frame: the last value is used.
- **Latency sweep.** FRAME_BUFFER_READ_LATENCY = 1, 2 and 4, with a RAM model of matching latency. Required:
  - Colour and sync are aligned.
  - The first pixel appears 2, 3 and 5 cycles after frame_start respectively.
  - Blanking colour is 0.
- **Reset mid-operation.** Assert resetn = 0 at (500, 300) with a swap pending. Required:
  - After release, counters restart at (0,0).
  - No swap_ack occurs and active_base = 0.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared types, timing helpers and colour expansion for the frame-buffer scanout path.
package fb_pkg;

   localparam int BPP_8  = 8;
   localparam int BPP_16 = 16;
   localparam int CW     = 16;   // h/v counter width

   localparam int H_TOTAL_DEF = 800 + 40 + 128 + 88;
   localparam int V_TOTAL_DEF = 600 + 1 + 4 + 23;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb444_t;

   // Per-pixel side information that travels alongside the RAM read.
   typedef struct packed {
      logic       vis;
      logic [1:0] lane;
      logic       hs;
      logic       vs;
   } scan_tap_t;

   function automatic int timing_total(input int vis, input int fp, input int sync, input int bp);
      return vis + fp + sync + bp;
   endfunction

   function automatic rgb444_t rgb332_expand(input logic [7:0] p);
      rgb444_t c;
      c.r = {p[7:5], p[7]};
      c.g = {p[4:2], p[4]};
      c.b = {p[1:0], p[1:0]};
      return c;
   endfunction

   function automatic rgb444_t rgb565_expand(input logic [15:0] p);
      rgb444_t c;
      c.r = p[15:12];
      c.g = p[10:7];
      c.b = p[4:1];
      return c;
   endfunction

endpackage

// File: rtl/fb_scanout_scan_timing.sv
// VGA raster counters with visible-area and raw (active-high) sync decode.
module scan_timing
   import fb_pkg::*;
#(
   parameter int H_VIS  = 800,
   parameter int H_FP   = 40,
   parameter int H_SYNC = 128,
   parameter int H_BP   = 88,
   parameter int V_VIS  = 600,
   parameter int V_FP   = 1,
   parameter int V_SYNC = 4,
   parameter int V_BP   = 23
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   output logic [CW-1:0] h_o,
   output logic [CW-1:0] v_o,
   output logic          visible_o,
   output logic          hs_raw_o,
   output logic          vs_raw_o,
   output logic          wrap_o
);

   localparam logic [CW-1:0] H_LAST = CW'(timing_total(H_VIS, H_FP, H_SYNC, H_BP) - 1);
   localparam logic [CW-1:0] V_LAST = CW'(timing_total(V_VIS, V_FP, V_SYNC, V_BP) - 1);
   localparam logic [CW-1:0] H_VISC = CW'(H_VIS);
   localparam logic [CW-1:0] V_VISC = CW'(V_VIS);
   localparam logic [CW-1:0] HS_BEG = CW'(H_VIS + H_FP);
   localparam logic [CW-1:0] HS_END = CW'(H_VIS + H_FP + H_SYNC);
   localparam logic [CW-1:0] VS_BEG = CW'(V_VIS + V_FP);
   localparam logic [CW-1:0] VS_END = CW'(V_VIS + V_FP + V_SYNC);

   logic [CW-1:0] h_q, h_d, v_q, v_d;
   logic          h_end, v_end;

   always_comb begin
      h_end = (h_q == H_LAST);
      v_end = (v_q == V_LAST);
      h_d   = h_end ? '0 : h_q + 1'b1;
      v_d   = v_q;
      if (h_end) v_d = v_end ? '0 : v_q + 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         h_q <= '0;
         v_q <= '0;
      end else begin
         h_q <= h_d;
         v_q <= v_d;
      end
   end

   assign h_o       = h_q;
   assign v_o       = v_q;
   assign visible_o = (h_q < H_VISC) && (v_q < V_VISC);
   assign hs_raw_o  = (h_q >= HS_BEG) && (h_q < HS_END);
   assign vs_raw_o  = (v_q >= VS_BEG) && (v_q < VS_END);
   assign wrap_o    = h_end && v_end;

endmodule

// File: rtl/fb_scanout.sv
// Frame-buffer scanout: scaled RAM addressing, double-buffered base, pixel unpack to 4-bit VGA.
module fb_scanout
   import fb_pkg::*;
#(
   parameter int H_VIS_AREA_PXL            = 800,
   parameter int H_FRONT_PORCH_PXL         = 40,
   parameter int H_SYNC_PULSE_PXL          = 128,
   parameter int H_BACK_PORCH_PXL          = 88,
   parameter int V_VIS_AREA_PXL            = 600,
   parameter int V_FRONT_PORCH_PXL         = 1,
   parameter int V_SYNC_PULSE_PXL          = 4,
   parameter int V_BACK_PORCH_PXL          = 23,
   parameter int SCALE_LOG2                = 1,
   parameter int BPP                       = BPP_8,
   parameter int FRAME_BUFFER_READ_LATENCY = 1,
   parameter bit SYNC_ACTIVE_HIGH          = 1'b1
) (
   input  logic        vga_clk,
   input  logic        resetn,
   input  logic [31:0] fb_base_in,
   input  logic        swap_req,
   output logic        swap_ack,
   output logic        frame_start,
   output logic [31:0] buffer_addr,
   output logic        buffer_en,
   input  logic [31:0] buffer_dout,
   output logic [3:0]  VGA_R,
   output logic [3:0]  VGA_G,
   output logic [3:0]  VGA_B,
   output logic        VGA_HS,
   output logic        VGA_VS
);

   localparam int          LAT        = FRAME_BUFFER_READ_LATENCY;
   localparam int          BYTES_LOG2 = (BPP == BPP_16) ? 1 : 0;
   localparam logic [31:0] LINE_PIX   = 32'(H_VIS_AREA_PXL >> SCALE_LOG2);

   logic [CW-1:0] h, v;
   logic          visible, hs_raw, vs_raw, wrap;

   scan_timing #(
      .H_VIS (H_VIS_AREA_PXL),    .H_FP(H_FRONT_PORCH_PXL),
      .H_SYNC(H_SYNC_PULSE_PXL),  .H_BP(H_BACK_PORCH_PXL),
      .V_VIS (V_VIS_AREA_PXL),    .V_FP(V_FRONT_PORCH_PXL),
      .V_SYNC(V_SYNC_PULSE_PXL),  .V_BP(V_BACK_PORCH_PXL)
   ) u_timing (
      .clk_i    (vga_clk),
      .rst_ni   (resetn),
      .h_o      (h),
      .v_o      (v),
      .visible_o(visible),
      .hs_raw_o (hs_raw),
      .vs_raw_o (vs_raw),
      .wrap_o   (wrap)
   );

   // Base only changes on the last cycle of a frame, so a frame never mixes bases.
   logic [31:0] active_base_q, active_base_d, pending_base_q, pending_base_d;
   logic        pending_valid_q, pending_valid_d, swap_now;

   always_comb begin
      active_base_d   = active_base_q;
      pending_base_d  = swap_req ? fb_base_in : pending_base_q;
      pending_valid_d = pending_valid_q | swap_req;
      swap_now        = wrap & (swap_req | pending_valid_q);
      if (swap_now) begin
         active_base_d   = swap_req ? fb_base_in : pending_base_q;
         pending_valid_d = 1'b0;
      end
   end

   always_ff @(posedge vga_clk or negedge resetn) begin
      if (!resetn) begin
         active_base_q   <= '0;
         pending_base_q  <= '0;
         pending_valid_q <= 1'b0;
      end else begin
         active_base_q   <= active_base_d;
         pending_base_q  <= pending_base_d;
         pending_valid_q <= pending_valid_d;
      end
   end

   logic [31:0] idx;
   assign idx         = (32'(v) >> SCALE_LOG2) * LINE_PIX + (32'(h) >> SCALE_LOG2);
   assign buffer_addr = visible ? active_base_q + (idx << BYTES_LOG2) : active_base_q;
   assign buffer_en   = visible & resetn;
   assign frame_start = resetn & (h == '0) & (v == '0);
   assign swap_ack    = resetn & swap_now;

   // Side info is delayed by the RAM latency so it lines up with buffer_dout.
   scan_tap_t             tap, out_tap;
   scan_tap_t [LAT-1:0]   tap_q;
   scan_tap_t [LAT:0]     tap_d;

   always_comb begin
      tap.vis  = visible;
      tap.lane = buffer_addr[1:0];
      tap.hs   = hs_raw;
      tap.vs   = vs_raw;
   end

   assign tap_d   = {tap_q, tap};
   assign out_tap = tap_q[LAT-1];

   always_ff @(posedge vga_clk or negedge resetn) begin
      if (!resetn) tap_q <= '0;
      else         tap_q <= tap_d[LAT-1:0];
   end

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   rgb444_t     pix, rgb_q;
   logic        hs_q, vs_q;

   always_comb begin
      byte_sel = buffer_dout[{out_tap.lane, 3'b000} +: 8];
      half_sel = out_tap.lane[1] ? buffer_dout[31:16] : buffer_dout[15:0];
      pix      = (BPP == BPP_16) ? rgb565_expand(half_sel) : rgb332_expand(byte_sel);
      if (!out_tap.vis) pix = '0;
   end

   always_ff @(posedge vga_clk or negedge resetn) begin
      if (!resetn) begin
         rgb_q <= '0;
         hs_q  <= ~SYNC_ACTIVE_HIGH;
         vs_q  <= ~SYNC_ACTIVE_HIGH;
      end else begin
         rgb_q <= pix;
         hs_q  <= SYNC_ACTIVE_HIGH ? out_tap.hs : ~out_tap.hs;
         vs_q  <= SYNC_ACTIVE_HIGH ? out_tap.vs : ~out_tap.vs;
      end
   end

   assign VGA_R  = rgb_q.r;
   assign VGA_G  = rgb_q.g;
   assign VGA_B  = rgb_q.b;
   assign VGA_HS = hs_q;
   assign VGA_VS = vs_q;

endmodule

// File: tb/tb_fb_scanout.sv
// Directed bench: three scanout configurations on a shrunken raster (24 x 12), logged per cycle and checked from a table.
module tb_fb_scanout;

   localparam int HV = 16, HF = 2, HSY = 4, HB = 2;
   localparam int VV = 8,  VF = 1, VSY = 2, VB = 1;

   logic vga_clk = 1'b0;
   always #5 vga_clk = ~vga_clk;

   logic        resetn   = 1'b0;
   logic        swap_req = 1'b0;
   logic        no_swap  = 1'b0;
   logic [31:0] fb_base_in = '0;

   logic [31:0] addr [3];
   logic [31:0] dout [3];
   logic        en [3], ack [3], fs [3], hs [3], vs [3];
   logic [3:0]  r [3], g [3], b [3];

   // u0: 8 bpp, scale 2, latency 1
   fb_scanout #(.H_VIS_AREA_PXL(HV), .H_FRONT_PORCH_PXL(HF), .H_SYNC_PULSE_PXL(HSY), .H_BACK_PORCH_PXL(HB),
                .V_VIS_AREA_PXL(VV), .V_FRONT_PORCH_PXL(VF), .V_SYNC_PULSE_PXL(VSY), .V_BACK_PORCH_PXL(VB),
                .SCALE_LOG2(1), .BPP(8), .FRAME_BUFFER_READ_LATENCY(1), .SYNC_ACTIVE_HIGH(1'b1)) u0 (
      .vga_clk(vga_clk), .resetn(resetn), .fb_base_in(fb_base_in), .swap_req(swap_req), .swap_ack(ack[0]),
      .frame_start(fs[0]), .buffer_addr(addr[0]), .buffer_en(en[0]), .buffer_dout(dout[0]),
      .VGA_R(r[0]), .VGA_G(g[0]), .VGA_B(b[0]), .VGA_HS(hs[0]), .VGA_VS(vs[0]));

   // u1: 16 bpp, no scaling, latency 2
   fb_scanout #(.H_VIS_AREA_PXL(HV), .H_FRONT_PORCH_PXL(HF), .H_SYNC_PULSE_PXL(HSY), .H_BACK_PORCH_PXL(HB),
                .V_VIS_AREA_PXL(VV), .V_FRONT_PORCH_PXL(VF), .V_SYNC_PULSE_PXL(VSY), .V_BACK_PORCH_PXL(VB),
                .SCALE_LOG2(0), .BPP(16), .FRAME_BUFFER_READ_LATENCY(2), .SYNC_ACTIVE_HIGH(1'b1)) u1 (
      .vga_clk(vga_clk), .resetn(resetn), .fb_base_in(fb_base_in), .swap_req(no_swap), .swap_ack(ack[1]),
      .frame_start(fs[1]), .buffer_addr(addr[1]), .buffer_en(en[1]), .buffer_dout(dout[1]),
      .VGA_R(r[1]), .VGA_G(g[1]), .VGA_B(b[1]), .VGA_HS(hs[1]), .VGA_VS(vs[1]));

   // u2: 8 bpp, no scaling, latency 4, active-low sync
   fb_scanout #(.H_VIS_AREA_PXL(HV), .H_FRONT_PORCH_PXL(HF), .H_SYNC_PULSE_PXL(HSY), .H_BACK_PORCH_PXL(HB),
                .V_VIS_AREA_PXL(VV), .V_FRONT_PORCH_PXL(VF), .V_SYNC_PULSE_PXL(VSY), .V_BACK_PORCH_PXL(VB),
                .SCALE_LOG2(0), .BPP(8), .FRAME_BUFFER_READ_LATENCY(4), .SYNC_ACTIVE_HIGH(1'b0)) u2 (
      .vga_clk(vga_clk), .resetn(resetn), .fb_base_in(fb_base_in), .swap_req(no_swap), .swap_ack(ack[2]),
      .frame_start(fs[2]), .buffer_addr(addr[2]), .buffer_en(en[2]), .buffer_dout(dout[2]),
      .VGA_R(r[2]), .VGA_G(g[2]), .VGA_B(b[2]), .VGA_HS(hs[2]), .VGA_VS(vs[2]));

   function automatic logic [31:0] ram_word(input int inst, input logic [31:0] a);
      logic [29:0] w;
      w = a[31:2];
      case (inst)
         0:       return (w == 0) ? 32'h1CE0_03FF : 32'h0;
         1:       return (w == 0) ? 32'h001F_F800 : (w == 1) ? 32'h07E0_FFFF : 32'h0;
         default: return (w == 0) ? 32'h4903_1CE0 : 32'h0;
      endcase
   endfunction

   // RAM models ignore the enable so that blanking is really exercised.
   logic [31:0] ram_p [3][4];
   always @(posedge vga_clk) begin
      for (int i = 0; i < 3; i++) begin
         ram_p[i][0] <= ram_word(i, addr[i]);
         for (int k = 1; k < 4; k++) ram_p[i][k] <= ram_p[i][k-1];
      end
   end
   assign dout[0] = ram_p[0][0];
   assign dout[1] = ram_p[1][1];
   assign dout[2] = ram_p[2][3];

   typedef struct packed {
      logic [31:0] addr;
      logic        en;
      logic        fs;
      logic        ack;
      logic        hs;
      logic        vs;
      logic [11:0] rgb;
   } obs_t;

   obs_t lg [3][2048];
   int   gcnt = 0;
   always @(negedge vga_clk) begin
      for (int j = 0; j < 3; j++)
         if (gcnt < 2048) lg[j][gcnt] <= {addr[j], en[j], fs[j], ack[j], hs[j], vs[j], r[j], g[j], b[j]};
      gcnt <= gcnt + 1;
   end

   typedef enum int {S_ADDR, S_EN, S_FS, S_ACK, S_RGB, S_HS, S_VS} sig_e;
   typedef struct {
      int          inst;
      int          ph;
      int          off;
      sig_e        sig;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[$];
   int   rel [2];
   int   n_run = 0, n_fail = 0;

   function automatic void add(input int inst, input int ph, input int off, input sig_e s, input logic [31:0] e);
      vecs.push_back('{inst, ph, off, s, e});
   endfunction

   function automatic logic [31:0] obs_get(input int inst, input int gi, input sig_e s);
      obs_t o;
      o = lg[inst][gi];
      case (s)
         S_ADDR:  return o.addr;
         S_EN:    return 32'(o.en);
         S_FS:    return 32'(o.fs);
         S_ACK:   return 32'(o.ack);
         S_RGB:   return 32'(o.rgb);
         S_HS:    return 32'(o.hs);
         default: return 32'(o.vs);
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic int count(input int inst, input int ph, input int c0, input int c1, input sig_e s, input logic [31:0] val);
      int n;
      n = 0;
      for (int c = c0; c <= c1; c++) if (obs_get(inst, rel[ph] + c, s) == val) n++;
      return n;
   endfunction

   initial begin
      // reset values, sampled while resetn is still low
      add(0,0,-2,S_ADDR,0); add(0,0,-2,S_EN,0); add(0,0,-2,S_FS,0); add(0,0,-2,S_ACK,0);
      add(0,0,-2,S_RGB,0);  add(0,0,-2,S_HS,0); add(0,0,-2,S_VS,0);
      add(1,0,-2,S_EN,0);   add(2,0,-2,S_HS,1); add(2,0,-2,S_VS,1); add(2,0,-2,S_RGB,0);
      // frame timing (frame = 288 cycles)
      add(0,0,0,S_FS,1);  add(0,0,1,S_FS,0);  add(0,0,287,S_FS,0); add(0,0,288,S_FS,1);
      add(0,0,19,S_HS,0); add(0,0,20,S_HS,1); add(0,0,23,S_HS,1);  add(0,0,24,S_HS,0);
      add(0,0,217,S_VS,0); add(0,0,218,S_VS,1); add(0,0,265,S_VS,1); add(0,0,266,S_VS,0);
      // 8 bpp, scale 2, latency 1
      add(0,0,1,S_RGB,12'h000); add(0,0,2,S_RGB,12'hFFF); add(0,0,3,S_RGB,12'hFFF);
      add(0,0,4,S_RGB,12'h00F); add(0,0,5,S_RGB,12'h00F); add(0,0,6,S_RGB,12'hF00);
      add(0,0,26,S_RGB,12'hFFF); add(0,0,18,S_RGB,12'h000);
      add(0,0,1,S_ADDR,0); add(0,0,2,S_ADDR,1); add(0,0,48,S_ADDR,8); add(0,0,48,S_EN,1);
      add(0,0,16,S_ADDR,0); add(0,0,16,S_EN,0);
      // 16 bpp, latency 2
      add(1,0,1,S_ADDR,2); add(1,0,2,S_ADDR,4); add(1,0,24,S_ADDR,32);
      add(1,0,2,S_RGB,12'h000); add(1,0,3,S_RGB,12'hF00); add(1,0,4,S_RGB,12'h00F);
      add(1,0,5,S_RGB,12'hFFF); add(1,0,6,S_RGB,12'h0F0); add(1,0,19,S_RGB,12'h000);
      add(1,0,290,S_RGB,12'h000); add(1,0,291,S_RGB,12'hF00);
      add(1,0,20,S_HS,0); add(1,0,21,S_HS,1); add(1,0,24,S_HS,1); add(1,0,25,S_HS,0);
      // 8 bpp, latency 4, active-low sync
      add(2,0,4,S_RGB,12'h000); add(2,0,5,S_RGB,12'hF00); add(2,0,6,S_RGB,12'h0F0);
      add(2,0,7,S_RGB,12'h00F); add(2,0,8,S_RGB,12'h445);
      add(2,0,292,S_RGB,12'h000); add(2,0,293,S_RGB,12'hF00);
      add(2,0,22,S_HS,1); add(2,0,23,S_HS,0); add(2,0,26,S_HS,0); add(2,0,27,S_HS,1);
      add(2,0,220,S_VS,1); add(2,0,221,S_VS,0); add(2,0,268,S_VS,0); add(2,0,269,S_VS,1);
      // double buffering on u0
      add(0,0,30,S_ADDR,3); add(0,0,170,S_ADDR,25);
      add(0,0,286,S_ACK,0); add(0,0,287,S_ACK,1); add(0,0,288,S_ACK,0);
      add(0,0,288,S_ADDR,32'h0001_0000); add(0,0,288,S_EN,1); add(0,0,336,S_ADDR,32'h0001_0008);
      add(0,0,574,S_ACK,0); add(0,0,574,S_ADDR,32'h0001_0000);
      add(0,0,575,S_ACK,1); add(0,0,576,S_ADDR,32'h0003_0000);
      // reset mid-frame with a swap pending
      add(0,1,-1,S_EN,0); add(0,1,-1,S_FS,0); add(0,1,-1,S_RGB,0); add(0,1,-1,S_ADDR,0); add(0,1,-1,S_ACK,0);
      add(0,1,0,S_FS,1); add(0,1,0,S_ADDR,0); add(0,1,0,S_EN,1); add(0,1,2,S_RGB,12'hFFF);
      add(0,1,30,S_ADDR,3); add(0,1,287,S_ACK,0); add(0,1,288,S_ADDR,0); add(0,1,288,S_FS,1);

      repeat (5) @(posedge vga_clk);
      #1;
      resetn = 1'b1;
      rel[0] = gcnt;
      for (int c = 0; c < 700; c++) begin
         swap_req   = (c >= 50 && c < 288) || c == 300 || c == 310 || c == 590;
         fb_base_in = (c < 288) ? 32'h0001_0000 : (c < 305) ? 32'h0002_0000 :
                      (c < 400) ? 32'h0003_0000 : 32'h0004_0000;
         @(posedge vga_clk);
         #1;
      end
      resetn     = 1'b0;
      swap_req   = 1'b0;
      fb_base_in = '0;
      repeat (3) @(posedge vga_clk);
      #1;
      resetn = 1'b1;
      rel[1] = gcnt;
      repeat (600) @(posedge vga_clk);
      @(negedge vga_clk);
      #1;

      foreach (vecs[i]) begin
         int gi;
         gi = rel[vecs[i].ph] + vecs[i].off;
         if (gi < 0 || gi >= gcnt || gi >= 2048)
            check($sformatf("u%0d ph%0d c%0d %s out-of-log", vecs[i].inst, vecs[i].ph, vecs[i].off, vecs[i].sig.name()),
                  32'hFFFF_FFFF, vecs[i].exp);
         else
            check($sformatf("u%0d ph%0d c%0d %s", vecs[i].inst, vecs[i].ph, vecs[i].off, vecs[i].sig.name()),
                  obs_get(vecs[i].inst, gi, vecs[i].sig), vecs[i].exp);
      end

      check("u0 hs_active_per_line", 32'(count(0,0,0,23,S_HS,1)), 4);
      check("u2 hs_low_per_line",    32'(count(2,0,5,28,S_HS,0)), 4);
      check("u0 vs_active_per_frame", 32'(count(0,0,0,287,S_VS,1)), 48);
      check("u0 frame_start_count",  32'(count(0,0,0,575,S_FS,1)), 2);
      check("u0 swap_ack_count_A",   32'(count(0,0,0,699,S_ACK,1)), 2);
      check("u0 swap_ack_count_B",   32'(count(0,1,0,599,S_ACK,1)), 0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
